// File: rtl/parity_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// parity_sweep_ctrl
//
// Exhaustive-sweep sequencer for an N-input XNOR parity gate. On START it
// drives every vector 0..2^N-1 onto STIM. It holds each vector for SETTLE+1
// cycles and samples Y on the last edge of that window. Each sample is compared
// with the expected XNOR parity (~^STIM). At the end of the sweep it reports
// PASS, a saturating mismatch count and the first failing vector.
//
// Parameters
//   N       gate input count / STIM width (1..8)
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//   ERRW    width of the mismatch counter
//
// Ports
//   CLK      in   1     rising-edge clock
//   RST      in   1     synchronous reset, active-high
//   START    in   1     sweep request, only honoured while idle
//   Y        in   1     output of the gate under test
//   STIM     out  N     registered vector driven to the gate (bit0=C1, bit1=C2, bit2=C4)
//   BUSY     out  1     sweep in progress
//   DONE     out  1     one-cycle pulse in the cycle after BUSY falls
//   PASS     out  1     last sweep had no mismatches
//   ERRCNT   out  ERRW  mismatch count of last sweep, saturating
//   FAILVEC  out  N     first mismatching vector of last sweep
//
// Build option
//   PARITY_SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//   sweep immediately. STIM then holds the failing vector and ERRCNT is 1.
//   When undefined, the full sweep always runs.
// -----------------------------------------------------------------------------
module parity_sweep_ctrl #(
  parameter int N      = 3,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            Y,
  output logic [N-1:0]    STIM,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERRCNT,
  output logic [N-1:0]    FAILVEC
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } stateT;

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE);
  localparam logic [N-1:0]    LAST_VEC    = '1;
  localparam logic [ERRW-1:0] ERR_MAX     = '1;

  stateT           stateReg, stateNext;
  logic [3:0]      settleReg, settleNext;
  logic [N-1:0]    stimReg, stimNext;
  logic            busyReg, busyNext;
  logic            doneReg, doneNext;
  logic            passReg, passNext;
  logic [ERRW-1:0] errReg, errNext;
  logic [N-1:0]    failReg, failNext;

  logic            expBit;
  logic            mismatch;
  logic            lastVec;
  logic            sweepEnd;

  // Expected gate output: 1 when the vector has an even number of ones.
  assign expBit   = ~^stimReg;
  assign mismatch = (stateReg == SAMPLE) && (Y != expBit);
  assign lastVec  = (stimReg == LAST_VEC);

`ifdef PARITY_SWEEP_STOP_ON_FAIL_EN
  assign sweepEnd = lastVec || mismatch;
`else
  assign sweepEnd = lastVec;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // With SETTLE = 0 the DRIVE state is skipped entirely, so each vector gets
  // exactly one SAMPLE cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (START) begin
          stateNext = (SETTLE_LOAD == 4'd0) ? SAMPLE : DRIVE;
        end
      end
      DRIVE: begin
        // The counter enters DRIVE holding SETTLE. Leaving when it reads 1
        // makes DRIVE last exactly SETTLE cycles.
        if (settleReg <= 4'd1) begin
          stateNext = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sweepEnd) begin
          stateNext = FIN;
        end else begin
          stateNext = (SETTLE_LOAD == 4'd0) ? SAMPLE : DRIVE;
        end
      end
      FIN: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values
  // All outputs are registered. BUSY and DONE are decoded from the next state,
  // so they line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    settleNext = settleReg;
    stimNext   = stimReg;
    passNext   = passReg;
    errNext    = errReg;
    failNext   = failReg;
    busyNext   = (stateNext == DRIVE) || (stateNext == SAMPLE);
    doneNext   = (stateNext == FIN);

    case (stateReg)
      IDLE: begin
        if (START) begin
          stimNext   = '0;
          errNext    = '0;
          failNext   = '0;
          passNext   = 1'b0;
          settleNext = SETTLE_LOAD;
        end
      end
      DRIVE: begin
        settleNext = settleReg - 4'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (errReg != ERR_MAX) begin
            errNext = errReg + ERRW'(1);
          end
          // The count only ever leaves zero on a mismatch, and it saturates
          // rather than wrapping. A zero count therefore means no earlier
          // mismatch has been seen in this sweep.
          if (errReg == '0) begin
            failNext = stimReg;
          end
        end
        if (sweepEnd) begin
          // PASS covers the final sample too, so use the updated count.
          passNext = (errNext == '0);
        end else begin
          stimNext   = stimReg + N'(1);
          settleNext = SETTLE_LOAD;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      settleReg <= '0;
      stimReg   <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      passReg   <= 1'b0;
      errReg    <= '0;
      failReg   <= '0;
    end else begin
      settleReg <= settleNext;
      stimReg   <= stimNext;
      busyReg   <= busyNext;
      doneReg   <= doneNext;
      passReg   <= passNext;
      errReg    <= errNext;
      failReg   <= failNext;
    end
  end

  assign STIM    = stimReg;
  assign BUSY    = busyReg;
  assign DONE    = doneReg;
  assign PASS    = passReg;
  assign ERRCNT  = errReg;
  assign FAILVEC = failReg;

endmodule

// File: tb/tb_parity_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_sweep_ctrl
//
// Directed bench for parity_sweep_ctrl with N=3 and SETTLE=2. It uses two
// instances that share START and RST:
//   dut  with ERRW=8
//   dut2 with ERRW=2, to exercise counter saturation
// A behavioural gate model drives Y for each instance from that instance's
// STIM. The model acts as a correct XNOR, as Y stuck at 1, or as an XOR.
// If PARITY_SWEEP_STOP_ON_FAIL_EN is defined, the bench expects
// stop-on-first-fail results.
// -----------------------------------------------------------------------------
module tb_parity_sweep_ctrl;

  localparam int N      = 3;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  int           gateMode;   // 0 = XNOR (good), 1 = stuck at 1, 2 = XOR
  logic         y, y2;
  logic [N-1:0] stim, stim2;
  logic         busy, busy2, done, done2, pass, pass2;
  logic [7:0]   errCnt;
  logic [1:0]   errCnt2;
  logic [N-1:0] failVec, failVec2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign y  = (gateMode == 0) ? ~^stim  : (gateMode == 1) ? 1'b1 : ^stim;
  assign y2 = (gateMode == 0) ? ~^stim2 : (gateMode == 1) ? 1'b1 : ^stim2;

  parity_sweep_ctrl #(.N(N), .SETTLE(SETTLE), .ERRW(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .Y(y),
    .STIM(stim), .BUSY(busy), .DONE(done), .PASS(pass),
    .ERRCNT(errCnt), .FAILVEC(failVec)
  );

  parity_sweep_ctrl #(.N(N), .SETTLE(SETTLE), .ERRW(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start), .Y(y2),
    .STIM(stim2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
    .ERRCNT(errCnt2), .FAILVEC(failVec2)
  );

  task automatic checkVal(input string tag, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Pulse START for one cycle and follow the sweep to its end.
  // If repulse is set, START is pulsed again while BUSY and again during DONE.
  task automatic runSweep(input string tag, input int busyExp, input int stimLast,
                          input int passExp, input int errExp, input int failExp,
                          input int err2Exp, input bit repulse);
    int n;
    int donesSeen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal({tag, ".busyStart"}, int'(busy), 1);
    checkVal({tag, ".stimStart"}, int'(stim), 0);
    n = 0;
    donesSeen = 0;
    while (busy && n < 200) begin
      checkVal({tag, ".stimStep"}, int'(stim), n / (SETTLE + 1));
      if (done) donesSeen++;
      n++;
      start = repulse && (n == 5);
      @(negedge clk);
    end
    start = 1'b0;
    checkVal({tag, ".busyLen"},  n, busyExp);
    checkVal({tag, ".doneEarly"}, donesSeen, 0);
    checkVal({tag, ".done"},     int'(done), 1);
    checkVal({tag, ".stimLast"}, int'(stim), stimLast);
    checkVal({tag, ".pass"},     int'(pass), passExp);
    checkVal({tag, ".errCnt"},   int'(errCnt), errExp);
    checkVal({tag, ".failVec"},  int'(failVec), failExp);
    checkVal({tag, ".done2"},    int'(done2), 1);
    checkVal({tag, ".pass2"},    int'(pass2), passExp);
    checkVal({tag, ".errCnt2"},  int'(errCnt2), err2Exp);
    checkVal({tag, ".failVec2"}, int'(failVec2), failExp);
    $display("sweep %s: busy=%0d stim=%0d pass=%0b errcnt=%0d failvec=%0d errcnt2=%0d",
             tag, n, stim, pass, errCnt, failVec, errCnt2);
    if (repulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal({tag, ".doneOnce"}, int'(done), 0);
    checkVal({tag, ".idleBusy"}, int'(busy), 0);
    checkVal({tag, ".stimHold"}, int'(stim), stimLast);
    checkVal({tag, ".passHold"}, int'(pass), passExp);
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    start    = 1'b0;
    gateMode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkVal("reset.stim",    int'(stim), 0);
    checkVal("reset.busy",    int'(busy), 0);
    checkVal("reset.done",    int'(done), 0);
    checkVal("reset.pass",    int'(pass), 0);
    checkVal("reset.errCnt",  int'(errCnt), 0);
    checkVal("reset.failVec", int'(failVec), 0);
    $display("reset: stim=%0d busy=%0b done=%0b pass=%0b errcnt=%0d failvec=%0d",
             stim, busy, done, pass, errCnt, failVec);

    // Correct XNOR gate.
    gateMode = 0;
    runSweep("good", 24, 7, 1, 0, 0, 0, 1'b0);

`ifdef PARITY_SWEEP_STOP_ON_FAIL_EN
    // Y stuck at 1: vector 0 matches and vector 1 fails, so BUSY lasts 2 x 3 cycles.
    gateMode = 1;
    runSweep("stuck1", 6, 1, 0, 1, 1, 1, 1'b0);
    // XOR: vector 0 fails immediately.
    gateMode = 2;
    runSweep("xor", 3, 0, 0, 1, 0, 1, 1'b0);
`else
    // Y stuck at 1: mismatches at vectors 1, 2, 4 and 7.
    gateMode = 1;
    runSweep("stuck1", 24, 7, 0, 4, 1, 3, 1'b0);
    // XOR: all 8 vectors mismatch. The 2-bit counter saturates at 3.
    gateMode = 2;
    runSweep("xor", 24, 7, 0, 8, 0, 3, 1'b0);
`endif

    // Reset mid-sweep while STIM = 4.
    gateMode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (stim != 3'd4 && k < 100) begin
      k++;
      @(negedge clk);
    end
    checkVal("midrst.reachStim4", int'(stim), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkVal("midrst.stim",    int'(stim), 0);
    checkVal("midrst.busy",    int'(busy), 0);
    checkVal("midrst.done",    int'(done), 0);
    checkVal("midrst.pass",    int'(pass), 0);
    checkVal("midrst.errCnt",  int'(errCnt), 0);
    checkVal("midrst.failVec", int'(failVec), 0);
    @(negedge clk);
    checkVal("midrst.staysIdle", int'(busy), 0);
    $display("midrst: stim=%0d busy=%0b done=%0b pass=%0b", stim, busy, done, pass);
    runSweep("afterRst", 24, 7, 1, 0, 0, 0, 1'b0);

    // START pulsed again while BUSY and during DONE; both pulses are ignored.
    gateMode = 0;
    runSweep("repulse", 24, 7, 1, 0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
